// File: rtl/fa_bist_checker.sv
// Self-test engine for a 1-bit full adder: sweeps all eight operand vectors and checks the 2-bit result.
// Optional macro FA_BIST_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 A_o,
  output logic                 B_o,
  output logic                 C_o,
  input  logic [1:0]           F_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [2:0]           first_err_vec_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [2:0]           r_vec;
  logic [CNT_W-1:0]     r_settleCnt;
  logic [ERR_CNT_W-1:0] r_errCnt;
  logic [2:0]           r_firstErr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;

  logic                 w_start;
  logic [1:0]           w_expected;
  logic                 w_mismatch;
  logic                 w_stop;
  logic [ERR_CNT_W-1:0] w_errCntNext;

  assign w_start    = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_expected = {1'b0, r_vec[2]} + {1'b0, r_vec[1]} + {1'b0, r_vec[0]};
  assign w_mismatch = (r_state == CHECK) && (F_i != w_expected);

`ifdef FA_BIST_STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_comb begin
    w_errCntNext = r_errCnt;
    if (w_mismatch && (r_errCnt != {ERR_CNT_W{1'b1}})) begin
      w_errCntNext = r_errCnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_i) w_nextState = SETTLE;
      SETTLE:  if (r_settleCnt == SETTLE_LAST) w_nextState = CHECK;
      CHECK:   w_nextState = ((r_vec == 3'd7) || w_stop) ? DONE : SETTLE;
      DONE:    if (start_i) w_nextState = SETTLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath and status registers; every output comes straight from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vec       <= 3'd0;
      r_settleCnt <= '0;
      r_errCnt    <= '0;
      r_firstErr  <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (w_start) begin
      r_vec       <= 3'd0;
      r_settleCnt <= '0;
      r_errCnt    <= '0;
      r_firstErr  <= 3'd0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: begin
          if (r_settleCnt != SETTLE_LAST) begin
            r_settleCnt <= r_settleCnt + CNT_W'(1);
          end
        end
        CHECK: begin
          r_errCnt <= w_errCntNext;
          // A zero count means no earlier mismatch in this sweep.
          if (w_mismatch && (r_errCnt == '0)) begin
            r_firstErr <= r_vec;
          end
          if (w_nextState == DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_errCntNext == '0);
          end else begin
            r_vec       <= r_vec + 3'd1;
            r_settleCnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign A_o             = r_vec[2];
  assign B_o             = r_vec[1];
  assign C_o             = r_vec[0];
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign err_cnt_o       = r_errCnt;
  assign first_err_vec_o = r_firstErr;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Self-checking bench for fa_bist_checker: a faultable adder model drives F_i, and a
// timeline model of the sweep predicts every output on every cycle.
module tb_fa_bist_checker;

  localparam int S   = 2;
  localparam int W   = 4;
  localparam int PER = S + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         A, B, C;
  logic [1:0]   F;
  logic         busy, done, pass;
  logic [W-1:0] errCnt;
  logic [2:0]   firstErr;

  int faultMode = 0;
  int nVec = 0;
  int nMiss = 0;
  int cyc = 0;
  bit chkEn = 1'b0;

  bit mActive = 1'b0;
  int mStart = 0;
  int mMode = 0;

  int k, lv, len, eBusy, eDone, eVec, eErr, eFirst, ePass;
  int nWait;

  always #5 clk = ~clk;

  // Adder under test: 0 = correct, 1 = sum bit stuck at 0, 2 = carry bit stuck at 0.
  function automatic logic [1:0] adderModel(input logic [2:0] v, input int mode);
    int s;
    logic [1:0] r;
    s = int'(v[2]) + int'(v[1]) + int'(v[0]);
    r = 2'(s);
    if (mode == 1) r[0] = 1'b0;
    if (mode == 2) r[1] = 1'b0;
    return r;
  endfunction

  function automatic bit isMismatch(input int v, input int mode);
    logic [2:0] vv;
    int s;
    vv = 3'(v);
    s = int'(vv[2]) + int'(vv[1]) + int'(vv[0]);
    return adderModel(vv, mode) != 2'(s);
  endfunction

  function automatic int lastVec(input int mode);
`ifdef FA_BIST_STOP_ON_ERR_EN
    for (int v = 0; v < 8; v++) begin
      if (isMismatch(v, mode)) return v;
    end
`endif
    return 7;
  endfunction

  assign F = adderModel({A, B, C}, faultMode);

  fa_bist_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .A_o(A), .B_o(B), .C_o(C), .F_i(F),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(errCnt), .first_err_vec_o(firstErr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sweep bookkeeping: a start is honoured only when no sweep is running.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mActive <= 1'b0;
    end else if (start && (!mActive || (cyc - mStart) >= (lastVec(mMode) + 1) * PER)) begin
      mActive <= 1'b1;
      mStart  <= cyc + 1;
      mMode   <= faultMode;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      eBusy = 0; eDone = 0; eVec = 0; eErr = 0; eFirst = 0; ePass = 0;
      if (mActive) begin
        k   = cyc - mStart;
        lv  = lastVec(mMode);
        len = (lv + 1) * PER;
        eBusy = (k < len) ? 1 : 0;
        eDone = 1 - eBusy;
        eVec  = (eBusy == 1) ? k / PER : lv;
        for (int v = 0; v <= lv; v++) begin
          if (isMismatch(v, mMode) && ((v + 1) * PER <= k)) begin
            if (eErr == 0) eFirst = v;
            eErr++;
          end
        end
        if (eErr > (1 << W) - 1) eErr = (1 << W) - 1;
        ePass = (eDone == 1 && eErr == 0) ? 1 : 0;
      end
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("pass", 32'(pass), 32'(ePass));
      checkOutput("operands", 32'({A, B, C}), 32'(eVec));
      checkOutput("err_cnt", 32'(errCnt), 32'(eErr));
      checkOutput("first_err", 32'(firstErr), 32'(eFirst));
    end
  end

  task automatic applyStimulus();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic runSweep(input string name, input int expCyc, input int expErr,
                          input int expFirst, input int expPass, input int expVec);
    int n;
    applyStimulus();
    waitDone(n);
    checkOutput({name, "_cycles"}, 32'(n), 32'(expCyc));
    checkOutput({name, "_err"}, 32'(errCnt), 32'(expErr));
    checkOutput({name, "_first"}, 32'(firstErr), 32'(expFirst));
    checkOutput({name, "_pass"}, 32'(pass), 32'(expPass));
    checkOutput({name, "_vec"}, 32'({A, B, C}), 32'(expVec));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk); #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_vec", 32'({A, B, C}), 32'd0);
    checkOutput("rst_err", 32'(errCnt), 32'd0);
    chkEn = 1'b1;
    rst = 1'b0;

    faultMode = 0;
    runSweep("clean", 24, 0, 0, 1, 7);

    faultMode = 1;
`ifdef FA_BIST_STOP_ON_ERR_EN
    runSweep("sum_stuck", 6, 1, 1, 0, 1);
`else
    runSweep("sum_stuck", 24, 4, 1, 0, 7);
`endif

    faultMode = 2;
`ifdef FA_BIST_STOP_ON_ERR_EN
    runSweep("carry_stuck", 12, 1, 3, 0, 3);
`else
    runSweep("carry_stuck", 24, 4, 3, 0, 7);
`endif

    // Abort a sweep while vector 4 is on the operands.
    faultMode = 1;
    applyStimulus();
    repeat (12) @(posedge clk); #2;
    checkOutput("mid_vec", 32'({A, B, C}), 32'd4);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_vec", 32'({A, B, C}), 32'd0);
    checkOutput("abort_err", 32'(errCnt), 32'd0);
    checkOutput("abort_first", 32'(firstErr), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    faultMode = 0;
    runSweep("after_reset", 24, 0, 0, 1, 7);

    // A second start at cycle 10 must not disturb the sweep.
    applyStimulus();
    repeat (9) @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    waitDone(nWait);
    checkOutput("busy_start_cycles", 32'(nWait + 10), 32'd24);
    checkOutput("busy_start_pass", 32'(pass), 32'd1);
    repeat (3) @(posedge clk);

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
